// File: rtl/alarm_ring_ctrl.sv
// alarm_ring_ctrl: alarm match detection and ring/snooze/stop state machine.
module alarm_ring_ctrl #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  input  logic [4:0] alarm_hour,
  input  logic [5:0] alarm_min,
  input  logic       alarm_en,
  input  logic       stop_btn,
  input  logic       snooze_btn,
  output logic       alarm_match,
  output logic       blink_alarm,
  output logic       ringing,
  output logic [1:0] snooze_left
);
  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;
  state_t     r_state, w_nstate;
  logic       r_match, r_match_d, r_blink, w_blink;
  logic [8:0] r_ring_cnt, w_ring_cnt, r_snz_cnt, w_snz_cnt;
  logic [1:0] r_left, w_left;
  logic       w_edge, w_abort;
  assign w_edge  = r_match && !r_match_d;
  assign w_abort = stop_btn || !alarm_en;
  always_comb begin
    w_nstate   = r_state;
    w_ring_cnt = r_ring_cnt;
    w_snz_cnt  = r_snz_cnt;
    w_left     = r_left;
    w_blink    = r_blink;
    case (r_state)
      IDLE: begin
        w_blink = 1'b0;
        if (w_edge) begin
          w_nstate   = RING;
          w_ring_cnt = 9'(RING_SECS);
          w_blink    = 1'b1;
          w_left     = 2'(MAX_SNOOZE);
        end
      end
      RING: begin
        if (w_abort) begin
          w_nstate = IDLE;
          w_left   = 2'd0;
          w_blink  = 1'b0;
        end else if (snooze_btn && r_left != 2'd0) begin
          w_nstate  = SNOOZE;
          w_snz_cnt = 9'(SNOOZE_SECS);
          w_left    = r_left - 2'd1;
          w_blink   = 1'b0;
        end else if (tick_1hz) begin
          w_ring_cnt = (r_ring_cnt != 9'd0) ? r_ring_cnt - 9'd1 : 9'd0;
          w_blink    = !r_blink;
          if (r_ring_cnt <= 9'd1) begin
            w_nstate = IDLE;
            w_left   = 2'd0;
            w_blink  = 1'b0;
          end
        end
      end
      SNOOZE: begin
        if (w_abort) begin
          w_nstate = IDLE;
          w_left   = 2'd0;
          w_blink  = 1'b0;
        end else if (tick_1hz) begin
          w_snz_cnt = (r_snz_cnt != 9'd0) ? r_snz_cnt - 9'd1 : 9'd0;
          if (r_snz_cnt <= 9'd1) begin
            w_nstate   = RING;
            w_ring_cnt = 9'(RING_SECS);
            w_blink    = 1'b1;
          end
        end
      end
      default: begin
        w_nstate = IDLE;
        w_left   = 2'd0;
        w_blink  = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_match    <= 1'b0;
      r_match_d  <= 1'b0;
      r_blink    <= 1'b0;
      r_ring_cnt <= 9'd0;
      r_snz_cnt  <= 9'd0;
      r_left     <= 2'd0;
    end else begin
      r_state    <= w_nstate;
      r_match    <= alarm_en && cur_hour == alarm_hour && cur_min == alarm_min && cur_sec == 6'd0;
      r_match_d  <= r_match;
      r_blink    <= w_blink;
      r_ring_cnt <= w_ring_cnt;
      r_snz_cnt  <= w_snz_cnt;
      r_left     <= w_left;
    end
  end
  assign alarm_match = r_match;
  assign blink_alarm = r_blink;
  assign ringing     = r_state == RING;
  assign snooze_left = r_left;
endmodule
